control_escritura_config: RTL and testbench

- Sequencer for clock/date/timer configuration mode. Drives config_mode (which counter group the push-buttons edit) and, on user confirm, commits the edited values to the RTC through a single-outstanding write handshake.
- Sits between the button debouncers, the configuration counter group and the RTC bus-interface write port.
- Snapshots the counter values before committing so button activity cannot corrupt an in-flight commit.

---
 rtl/control_escritura_config_pkg.sv | 78 +++++++
 rtl/control_escritura_config_tabla_comandos_rtc.sv | 67 ++++++
 rtl/control_escritura_config.sv | 215 +++++++++++++++++++++
 tb/tb_control_escritura_config.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_escritura_config_pkg.sv
// -----------------------------------------------------------------------------
// control_escritura_config_pkg
//
// Shared definitions for the configuration-write sequencer:
//   - config_mode encodings (which counter group the push-buttons edit)
//   - sel_mode codes (group chosen at entry)
//   - FSM state encoding
//   - RTC register addresses and default transfer-command addresses
//   - per-group write counts and the snapshot data-select codes
// -----------------------------------------------------------------------------
package control_escritura_config_pkg;

  // Counter group being edited, as seen by the configuration counters.
  typedef enum logic [2:0] {
    CFGM_NORMAL = 3'd0,
    CFGM_HORA   = 3'd1,
    CFGM_FECHA  = 3'd2,
    CFGM_TIMER  = 3'd4
  } cfg_mode_e;

  // Group selector sampled on entry to configuration mode.
  typedef enum logic [1:0] {
    SEL_HORA    = 2'd0,
    SEL_FECHA   = 2'd1,
    SEL_TIMER   = 2'd2,
    SEL_INVALID = 2'd3
  } sel_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_LATCH,
    ST_WRITE,
    ST_GAP,
    ST_DONE
  } state_e;

  // Which snapshot slot feeds wr_data; command writes carry a zero byte.
  typedef enum logic [2:0] {
    DSEL_SLOT0,
    DSEL_SLOT1,
    DSEL_SLOT2,
    DSEL_SLOT3,
    DSEL_ZERO
  } dsel_e;

  typedef logic [2:0] idx_t;

  // RTC register map.
  localparam logic [7:0] ADDR_SS          = 8'h21;
  localparam logic [7:0] ADDR_MM          = 8'h22;
  localparam logic [7:0] ADDR_HH          = 8'h23;
  localparam logic [7:0] ADDR_DAY         = 8'h24;
  localparam logic [7:0] ADDR_MES         = 8'h25;
  localparam logic [7:0] ADDR_YEAR        = 8'h26;
  localparam logic [7:0] ADDR_DIA_SEMANA  = 8'h27;
  localparam logic [7:0] ADDR_SS_T        = 8'h41;
  localparam logic [7:0] ADDR_MM_T        = 8'h42;
  localparam logic [7:0] ADDR_HH_T        = 8'h43;

  localparam logic [7:0] CMD_HORA_ADDR_DEF  = 8'hF1;
  localparam logic [7:0] CMD_TIMER_ADDR_DEF = 8'hF2;

  // Writes per group, including the trailing transfer command.
  localparam idx_t N_WR_HORA  = 3'd4;
  localparam idx_t N_WR_FECHA = 3'd5;
  localparam idx_t N_WR_TIMER = 3'd4;

  function automatic cfg_mode_e mode_of_group(input sel_mode_e grupo);
    case (grupo)
      SEL_HORA:  return CFGM_HORA;
      SEL_FECHA: return CFGM_FECHA;
      SEL_TIMER: return CFGM_TIMER;
      default:   return CFGM_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/control_escritura_config_tabla_comandos_rtc.sv
// -----------------------------------------------------------------------------
// tabla_comandos_rtc
//
// Purely combinational write table: maps (group, index) to the RTC address,
// the snapshot slot that supplies the data byte, and a flag marking the
// group's final entry (the transfer command).
//
// Ports:
//   grupo  in   group being committed (hora / fecha / timer)
//   index  in   position within the group's write sequence
//   addr   out  RTC register address for this entry
//   dsel   out  snapshot slot feeding wr_data (or zero for commands)
//   last   out  high on the group's last entry
// -----------------------------------------------------------------------------
module tabla_comandos_rtc
  import control_escritura_config_pkg::*;
#(
  parameter logic [7:0] CMD_HORA_ADDR  = CMD_HORA_ADDR_DEF,
  parameter logic [7:0] CMD_TIMER_ADDR = CMD_TIMER_ADDR_DEF
) (
  input  sel_mode_e   grupo,
  input  idx_t        index,
  output logic [7:0]  addr,
  output dsel_e       dsel,
  output logic        last
);

  // NOTE: every output gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    addr = 8'h00;
    dsel = DSEL_ZERO;
    last = 1'b0;
    case (grupo)
      SEL_FECHA: begin
        last = (index >= N_WR_FECHA - 3'd1);
        case (index)
          3'd0:    begin addr = ADDR_DAY;        dsel = DSEL_SLOT0; end
          3'd1:    begin addr = ADDR_MES;        dsel = DSEL_SLOT1; end
          3'd2:    begin addr = ADDR_YEAR;       dsel = DSEL_SLOT2; end
          3'd3:    begin addr = ADDR_DIA_SEMANA; dsel = DSEL_SLOT3; end
          default: begin addr = CMD_HORA_ADDR;   dsel = DSEL_ZERO;  end
        endcase
      end
      SEL_TIMER: begin
        last = (index >= N_WR_TIMER - 3'd1);
        case (index)
          3'd0:    begin addr = ADDR_SS_T;      dsel = DSEL_SLOT0; end
          3'd1:    begin addr = ADDR_MM_T;      dsel = DSEL_SLOT1; end
          3'd2:    begin addr = ADDR_HH_T;      dsel = DSEL_SLOT2; end
          default: begin addr = CMD_TIMER_ADDR; dsel = DSEL_ZERO;  end
        endcase
      end
      default: begin
        // Hora; the invalid code never reaches a commit.
        last = (index >= N_WR_HORA - 3'd1);
        case (index)
          3'd0:    begin addr = ADDR_SS;       dsel = DSEL_SLOT0; end
          3'd1:    begin addr = ADDR_MM;       dsel = DSEL_SLOT1; end
          3'd2:    begin addr = ADDR_HH;       dsel = DSEL_SLOT2; end
          default: begin addr = CMD_HORA_ADDR; dsel = DSEL_ZERO;  end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_escritura_config.sv
// -----------------------------------------------------------------------------
// control_escritura_config
//
// Configuration-mode sequencer. Tells the counter group which fields the
// push-buttons edit (config_mode) and, on confirm, snapshots the edited
// values and commits them to the RTC through a single-outstanding write
// handshake (wr_req held until wr_ack, one idle cycle between writes).
//
// Optional feature (macro ACK_TIMEOUT_EN): adds parameter ACK_TIMEOUT and
// output wr_err. A write left unacknowledged for ACK_TIMEOUT cycles aborts
// the commit, pulses wr_err and returns to IDLE without commit_done.
//
// Ports:
//   clk                 in   system clock
//   reset               in   synchronous, active-low reset
//   btn_config          in   debounced level; rising edge = enter/confirm
//   btn_cancel          in   debounced level; rising edge = abandon edit
//   sel_mode[1:0]       in   group at entry: 0 hora, 1 fecha, 2 timer
//   data_*[7:0]         in   counter values (time, date, timer)
//   wr_ack              in   RTC interface accepted the current write
//   config_mode[2:0]    out  0 normal, 1 hora, 2 fecha, 4 timer
//   wr_req              out  write request
//   wr_addr[7:0]        out  write address (0 when idle)
//   wr_data[7:0]        out  write data (0 when idle)
//   busy                out  commit in progress
//   commit_done         out  one-cycle pulse after the last acknowledged write
//   wr_err              out  (ACK_TIMEOUT_EN only) one-cycle timeout pulse
// -----------------------------------------------------------------------------
module control_escritura_config
  import control_escritura_config_pkg::*;
#(
  parameter logic [7:0]  CMD_HORA_ADDR  = CMD_HORA_ADDR_DEF,
  parameter logic [7:0]  CMD_TIMER_ADDR = CMD_TIMER_ADDR_DEF
`ifdef ACK_TIMEOUT_EN
  ,
  parameter int unsigned ACK_TIMEOUT    = 1024
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_config,
  input  logic       btn_cancel,
  input  logic [1:0] sel_mode,
  input  logic [7:0] data_SS,
  input  logic [7:0] data_MM,
  input  logic [7:0] data_HH,
  input  logic [7:0] data_DAY,
  input  logic [7:0] data_MES,
  input  logic [7:0] data_YEAR,
  input  logic [7:0] data_dia_semana,
  input  logic [7:0] data_SS_T,
  input  logic [7:0] data_MM_T,
  input  logic [7:0] data_HH_T,
  input  logic       wr_ack,
  output logic [2:0] config_mode,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       commit_done
`ifdef ACK_TIMEOUT_EN
  ,
  output logic       wr_err
`endif
);

  state_e          state_q, state_d;
  sel_mode_e       grupo_q;
  idx_t            index_q;
  logic [3:0][7:0] snap_q;
  logic            btn_config_q, btn_cancel_q;
  logic            config_edge, cancel_edge;

  logic [7:0]      tab_addr;
  dsel_e           tab_dsel;
  logic            tab_last;
  logic [7:0]      sel_data;

  // A held level never re-triggers: only a 0->1 transition counts.
  assign config_edge = btn_config & ~btn_config_q;
  assign cancel_edge = btn_cancel & ~btn_cancel_q;

`ifdef ACK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] ack_cnt_q;
  logic             ack_timeout;

  // Fires in the ACK_TIMEOUT-th consecutive unacknowledged WRITE cycle.
  assign ack_timeout = (state_q == ST_WRITE) && !wr_ack &&
                       (ack_cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_cnt_q <= '0;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= ack_timeout;
      if (state_q == ST_WRITE && !wr_ack && !ack_timeout)
        ack_cnt_q <= ack_cnt_q + 1'b1;
      else
        ack_cnt_q <= '0;
    end
  end
`endif

  tabla_comandos_rtc #(
    .CMD_HORA_ADDR  (CMD_HORA_ADDR),
    .CMD_TIMER_ADDR (CMD_TIMER_ADDR)
  ) u_tabla (
    .grupo (grupo_q),
    .index (index_q),
    .addr  (tab_addr),
    .dsel  (tab_dsel),
    .last  (tab_last)
  );

  // NOTE: non-blocking assignments for every sequential register, so all
  // flops update from the values present before the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grupo_q      <= SEL_HORA;
      index_q      <= '0;
      btn_config_q <= 1'b0;
      btn_cancel_q <= 1'b0;
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is
      // cleared together with the rest of the state.
      snap_q       <= '0;
    end else begin
      state_q      <= state_d;
      btn_config_q <= btn_config;
      btn_cancel_q <= btn_cancel;

      if (state_q == ST_IDLE && config_edge && sel_mode != SEL_INVALID)
        grupo_q <= sel_mode_e'(sel_mode);

      // The snapshot is taken while config_mode is 0, so counters are
      // frozen and button activity cannot corrupt the commit.
      if (state_q == ST_LATCH) begin
        case (grupo_q)
          SEL_FECHA: snap_q <= {data_dia_semana, data_YEAR, data_MES, data_DAY};
          SEL_TIMER: snap_q <= {8'h00, data_HH_T, data_MM_T, data_SS_T};
          default:   snap_q <= {8'h00, data_HH, data_MM, data_SS};
        endcase
      end

      if (state_q == ST_LATCH)
        index_q <= '0;
      else if (state_q == ST_WRITE && wr_ack && !tab_last)
        index_q <= index_q + 3'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    config_mode = CFGM_NORMAL;
    wr_req      = 1'b0;
    busy        = 1'b0;
    commit_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (config_edge && sel_mode != SEL_INVALID)
          state_d = ST_CFG;
      end
      ST_CFG: begin
        config_mode = mode_of_group(grupo_q);
        // Cancel wins over a simultaneous confirm.
        if (cancel_edge)
          state_d = ST_IDLE;
        else if (config_edge)
          state_d = ST_LATCH;
      end
      ST_LATCH: begin
        busy    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        busy   = 1'b1;
        wr_req = 1'b1;
        if (wr_ack)
          state_d = tab_last ? ST_DONE : ST_GAP;
`ifdef ACK_TIMEOUT_EN
        else if (ack_timeout)
          state_d = ST_IDLE;
`endif
      end
      ST_GAP: begin
        busy    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        commit_done = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (tab_dsel)
      DSEL_SLOT0: sel_data = snap_q[0];
      DSEL_SLOT1: sel_data = snap_q[1];
      DSEL_SLOT2: sel_data = snap_q[2];
      DSEL_SLOT3: sel_data = snap_q[3];
      default:    sel_data = 8'h00;
    endcase
  end

  // Address and data bus stay at zero whenever no write is requested.
  assign wr_addr = wr_req ? tab_addr : 8'h00;
  assign wr_data = wr_req ? sel_data : 8'h00;

endmodule

// File: tb/tb_control_escritura_config.sv
// -----------------------------------------------------------------------------
// tb_control_escritura_config
//
// Self-checking bench for control_escritura_config. A transaction-level
// model (edit flag, queue of pending (addr,data) writes, gap/done flags)
// predicts every output each cycle; directed scenarios add hand-computed
// literal expectations (write lists, pulse counts, latencies).
// Define ACK_TIMEOUT_EN to also exercise the acknowledge timeout.
// -----------------------------------------------------------------------------
module tb_control_escritura_config;

  localparam int TB_TIMEOUT = 8;
  localparam int ACK_DLY    = 3;

  typedef logic [15:0] wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_config = 1'b0;
  logic       btn_cancel = 1'b0;
  logic [1:0] sel_mode = 2'd0;
  logic [7:0] data_SS = 8'h00, data_MM = 8'h00, data_HH = 8'h00;
  logic [7:0] data_DAY = 8'h00, data_MES = 8'h00, data_YEAR = 8'h00;
  logic [7:0] data_dia_semana = 8'h00;
  logic [7:0] data_SS_T = 8'h00, data_MM_T = 8'h00, data_HH_T = 8'h00;
  logic       wr_ack = 1'b0;

  logic [2:0] config_mode;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       commit_done;
`ifdef ACK_TIMEOUT_EN
  logic       wr_err;
`endif

  always #5 clk = ~clk;

  control_escritura_config #(
    .CMD_HORA_ADDR  (8'hF1),
    .CMD_TIMER_ADDR (8'hF2)
`ifdef ACK_TIMEOUT_EN
    ,
    .ACK_TIMEOUT    (TB_TIMEOUT)
`endif
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_config      (btn_config),
    .btn_cancel      (btn_cancel),
    .sel_mode        (sel_mode),
    .data_SS         (data_SS),
    .data_MM         (data_MM),
    .data_HH         (data_HH),
    .data_DAY        (data_DAY),
    .data_MES        (data_MES),
    .data_YEAR       (data_YEAR),
    .data_dia_semana (data_dia_semana),
    .data_SS_T       (data_SS_T),
    .data_MM_T       (data_MM_T),
    .data_HH_T       (data_HH_T),
    .wr_ack          (wr_ack),
    .config_mode     (config_mode),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .busy            (busy),
    .commit_done     (commit_done)
`ifdef ACK_TIMEOUT_EN
    ,
    .wr_err          (wr_err)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- acknowledge responder ----------------
  // Mode 0: wr_ack follows ack_level. Mode 1: ack in the ACK_DLY-th cycle of
  // each request.
  int   ack_mode  = 0;
  logic ack_level = 1'b0;
  int   ack_wait  = 0;

  always @(posedge clk) begin
    #3;
    if (ack_mode == 0) begin
      ack_wait = 0;
      wr_ack   = ack_level;
    end else if (wr_req) begin
      ack_wait++;
      wr_ack = (ack_wait >= ACK_DLY);
    end else begin
      ack_wait = 0;
      wr_ack   = 1'b0;
    end
  end

  // ---------------- behavioural model ----------------
  wr_t  m_q[$];
  bit   m_edit, m_latch, m_gap, m_done, m_err;
  int   m_grp  = 0;
  int   m_wait = 0;
  logic m_prev_cfg = 1'b0, m_prev_can = 1'b0;
  bit   m_ce, m_ca;

  always @(posedge clk) begin
    m_ce = btn_config && !m_prev_cfg;
    m_ca = btn_cancel && !m_prev_can;
    m_prev_cfg = btn_config;
    m_prev_can = btn_cancel;
    m_err = 1'b0;
    if (!reset) begin
      m_q.delete();
      m_edit = 0; m_latch = 0; m_gap = 0; m_done = 0; m_wait = 0;
      m_prev_cfg = 1'b0; m_prev_can = 1'b0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_latch) begin
      m_latch = 0;
      case (m_grp)
        0: m_q = '{{8'h21, data_SS}, {8'h22, data_MM}, {8'h23, data_HH}, 16'hF100};
        1: m_q = '{{8'h24, data_DAY}, {8'h25, data_MES}, {8'h26, data_YEAR},
                   {8'h27, data_dia_semana}, 16'hF100};
        default: m_q = '{{8'h41, data_SS_T}, {8'h42, data_MM_T}, {8'h43, data_HH_T}, 16'hF200};
      endcase
    end else if (m_q.size() != 0) begin
      if (m_gap) m_gap = 0;
      else if (wr_ack) begin
        void'(m_q.pop_front());
        m_wait = 0;
        if (m_q.size() == 0) m_done = 1; else m_gap = 1;
      end
`ifdef ACK_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TB_TIMEOUT) begin
          m_q.delete();
          m_wait = 0;
          m_err  = 1'b1;
        end
      end
`endif
    end else if (m_edit) begin
      if (m_ca) m_edit = 0;
      else if (m_ce) begin m_edit = 0; m_latch = 1; end
    end else if (m_ce && sel_mode != 2'd3) begin
      m_edit = 1;
      m_grp  = int'(sel_mode);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit         chk_en = 0;
  logic [2:0] e_cfg;
  logic       e_req;
  wr_t        e_wr;

  always @(negedge clk) begin
    if (chk_en) begin
      e_cfg = !m_edit ? 3'd0 : (m_grp == 0) ? 3'd1 : (m_grp == 1) ? 3'd2 : 3'd4;
      e_req = (m_q.size() != 0) && !m_gap;
      e_wr  = e_req ? m_q[0] : 16'h0000;
      check("config_mode", 16'(config_mode), 16'(e_cfg));
      check("wr_req", 16'(wr_req), 16'(e_req));
      check("wr_addr_data", {wr_addr, wr_data}, e_wr);
      check("busy", 16'(busy), 16'(m_latch || m_q.size() != 0 || m_done));
      check("commit_done", 16'(commit_done), 16'(m_done));
`ifdef ACK_TIMEOUT_EN
      check("wr_err", 16'(wr_err), 16'(m_err));
`endif
    end
  end

  // ---------------- activity log ----------------
  wr_t obs[$];
  int  n_done = 0, n_req = 0, n_errp = 0;

  always @(negedge clk) begin
    if (wr_req === 1'b1 && wr_ack === 1'b1) obs.push_back({wr_addr, wr_data});
    if (commit_done === 1'b1) n_done++;
    if (wr_req === 1'b1) n_req++;
`ifdef ACK_TIMEOUT_EN
    if (wr_err === 1'b1) n_errp++;
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press_config();
    btn_config = 1'b1;
    tick();
    btn_config = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (busy === 1'b0 && wr_req === 1'b0) break;
      tick();
    end
    check(name, 16'(i < 200), 16'd1);
    repeat (2) tick();
  endtask

  task automatic check_log(input string name, input int base, input wr_t exp_w[$]);
    check({name, " count"}, 16'(obs.size() - base), 16'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      check(name, (base + i < obs.size()) ? obs[base + i] : 16'hDEAD, exp_w[i]);
  endtask

  int b_obs, b_done, b_req, b_err;

  task automatic mark();
    b_obs = obs.size(); b_done = n_done; b_req = n_req; b_err = n_errp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    reset = 1'b0;
    tick();
    chk_en = 1;
    repeat (2) tick();
    check("rst config_mode", 16'(config_mode), 16'd0);
    check("rst wr_req", 16'(wr_req), 16'd0);
    check("rst busy", 16'(busy), 16'd0);
    check("rst addr_data", {wr_addr, wr_data}, 16'h0000);
    reset = 1'b1;
    tick();

    // Hora commit with zero-wait ack
    mark();
    sel_mode = 2'd0;
    press_config();
    check("t1 config_mode", 16'(config_mode), 16'd1);
    data_SS = 8'h45; data_MM = 8'h30; data_HH = 8'h12;
    ack_mode = 0; ack_level = 1'b1;
    btn_config = 1'b1;              // confirm edge cycle
    tick();                         // LATCH
    check("t1 latch cfg", 16'(config_mode), 16'd0);
    check("t1 latch req", 16'(wr_req), 16'd0);
    tick();                         // first WRITE, 2 cycles after the edge
    check("t1 first write", {7'd0, wr_req, wr_addr}, {7'd0, 1'b1, 8'h21});
    btn_config = 1'b0;
    wait_idle("t1 finish");
    check_log("t1 writes", b_obs, '{16'h2145, 16'h2230, 16'h2312, 16'hF100});
    check("t1 done pulses", 16'(n_done - b_done), 16'd1);
    check("t1 req cycles", 16'(n_req - b_req), 16'd4);
    ack_level = 1'b0;

    // Fecha commit, sel_mode changed in CFG, ack delayed 3 cycles
    mark();
    sel_mode = 2'd1;
    press_config();
    sel_mode = 2'd2;
    tick();
    check("t2 config_mode", 16'(config_mode), 16'd2);
    data_DAY = 8'h15; data_MES = 8'h07; data_YEAR = 8'h24; data_dia_semana = 8'h03;
    ack_mode = 1;
    btn_config = 1'b1;
    tick();
    btn_config = 1'b0;
    wait_idle("t2 finish");
    check_log("t2 writes", b_obs, '{16'h2415, 16'h2507, 16'h2624, 16'h2703, 16'hF100});
    check("t2 done pulses", 16'(n_done - b_done), 16'd1);
    check("t2 req cycles", 16'(n_req - b_req), 16'd15);

    // Timer entry, simultaneous cancel and confirm: cancel wins
    mark();
    sel_mode = 2'd2;
    press_config();
    check("t3 config_mode", 16'(config_mode), 16'd4);
    btn_config = 1'b1; btn_cancel = 1'b1;
    tick();
    check("t3 after cancel", 16'(config_mode), 16'd0);
    btn_config = 1'b0; btn_cancel = 1'b0;
    repeat (4) tick();
    check("t3 no writes", 16'(n_req - b_req), 16'd0);
    check("t3 busy", 16'(busy), 16'd0);

    // Invalid group does not enter configuration
    sel_mode = 2'd3;
    press_config();
    check("t3b invalid sel", 16'(config_mode), 16'd0);

    // Timer commit, data changes mid-commit, confirm held high
    mark();
    sel_mode = 2'd2;
    press_config();
    data_SS_T = 8'h10; data_MM_T = 8'h20; data_HH_T = 8'h08;
    ack_mode = 1;
    btn_config = 1'b1;
    tick();
    tick();
    data_SS_T = 8'h11;
    wait_idle("t4 finish");
    repeat (3) tick();
    check("t4 held no retrigger", 16'(config_mode), 16'd0);
    check_log("t4 writes", b_obs, '{16'h4110, 16'h4220, 16'h4308, 16'hF200});
    btn_config = 1'b0;
    tick();

    // Reset during the second fecha write
    mark();
    sel_mode = 2'd1;
    press_config();
    ack_mode = 1;
    btn_config = 1'b1;
    tick();
    btn_config = 1'b0;
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        if (obs.size() == b_obs + 1 && wr_req === 1'b1) break;
        tick();
      end
      check("t5 reach 2nd write", 16'(i < 50), 16'd1);
    end
    reset = 1'b0;
    tick();
    check("t5 rst req", 16'(wr_req), 16'd0);
    check("t5 rst outputs", {5'd0, config_mode, wr_addr}, 16'h0000);
    check("t5 rst busy_done", {14'd0, busy, commit_done}, 16'h0000);
    reset = 1'b1;
    ack_mode = 0; ack_level = 1'b1;
    repeat (5) tick();
    check("t5 no more writes", 16'(obs.size() - b_obs), 16'd1);
    check("t5 no commit_done", 16'(n_done - b_done), 16'd0);
    ack_level = 1'b0;
    tick();

`ifdef ACK_TIMEOUT_EN
    // Never acknowledged: abort after TB_TIMEOUT request cycles
    mark();
    sel_mode = 2'd0;
    press_config();
    ack_mode = 0; ack_level = 1'b0;
    btn_config = 1'b1;
    tick();
    btn_config = 1'b0;
    wait_idle("t6 finish");
    check("t6 req cycles", 16'(n_req - b_req), 16'(TB_TIMEOUT));
    check("t6 err pulses", 16'(n_errp - b_err), 16'd1);
    check("t6 no commit_done", 16'(n_done - b_done), 16'd0);
    check("t6 no writes", 16'(obs.size() - b_obs), 16'd0);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
